// File: rtl/lsu_exec.sv
// lsu_exec: load/store execution stage. Computes vj+A, reports store addresses
// to the ROB, queues loads in order and reads them one at a time.

module lsu_ext #(
  parameter int                TYPE_W = 6,
  parameter logic [TYPE_W-1:0] T_LB   = TYPE_W'(1),
  parameter logic [TYPE_W-1:0] T_LH   = TYPE_W'(2),
  parameter logic [TYPE_W-1:0] T_LBU  = TYPE_W'(4),
  parameter logic [TYPE_W-1:0] T_LHU  = TYPE_W'(5)
) (
  input  logic [TYPE_W-1:0] typ,
  input  logic [31:0]       raw,
  output logic [31:0]       val
);
  always_comb begin
    val = raw;
    case (typ)
      T_LB:    val = {{24{raw[7]}}, raw[7:0]};
      T_LBU:   val = {24'd0, raw[7:0]};
      T_LH:    val = {{16{raw[15]}}, raw[15:0]};
      T_LHU:   val = {16'd0, raw[15:0]};
      default: val = raw;
    endcase
  end
endmodule

module lsu_exec #(
  parameter int                DEPTH  = 4,
  parameter int                ROB_W  = 4,
  parameter int                TYPE_W = 6,
  parameter logic [TYPE_W-1:0] T_LB   = TYPE_W'(1),
  parameter logic [TYPE_W-1:0] T_LH   = TYPE_W'(2),
  parameter logic [TYPE_W-1:0] T_LW   = TYPE_W'(3),
  parameter logic [TYPE_W-1:0] T_LBU  = TYPE_W'(4),
  parameter logic [TYPE_W-1:0] T_LHU  = TYPE_W'(5),
  parameter logic [TYPE_W-1:0] T_SB   = TYPE_W'(6),
  parameter logic [TYPE_W-1:0] T_SH   = TYPE_W'(7),
  parameter logic [TYPE_W-1:0] T_SW   = TYPE_W'(8)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              au_en_in,
  input  logic [31:0]       au_A_in,
  input  logic [31:0]       au_vj_in,
  input  logic [ROB_W-1:0]  au_dest_in,
  input  logic [TYPE_W-1:0] au_inst_type_in,
  output logic              lbuffer_rdy_out,
  input  logic              rob_flush_in,
  output logic              rob_addr_en_out,
  output logic [ROB_W-1:0]  rob_addr_dest_out,
  output logic [31:0]       rob_addr_out,
  output logic              memctrl_en_out,
  output logic [31:0]       memctrl_addr_out,
  output logic [1:0]        memctrl_len_out,
  input  logic              memctrl_done_in,
  input  logic [31:0]       memctrl_data_in,
  output logic              cdb_lbuffer_en_out,
  output logic [ROB_W-1:0]  cdb_lbuffer_dest_out,
  output logic [31:0]       cdb_lbuffer_value_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] RDY_MAX = (CNT_W+1)'(DEPTH - 2);

  typedef struct packed {
    logic [ROB_W-1:0]  dest;
    logic [TYPE_W-1:0] typ;
    logic [31:0]       addr;
  } ld_req_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t            state_q, state_d;
  ld_req_t           fifo_q [DEPTH];
  ld_req_t           fifo_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ld_req_t           cur_q, cur_d;
  logic              mem_en_q, mem_en_d;
  logic              rob_en_q, rob_en_d;
  logic [ROB_W-1:0]  rob_dest_q, rob_dest_d;
  logic [31:0]       rob_addr_q, rob_addr_d;
  logic              cdb_en_q, cdb_en_d;
  logic [ROB_W-1:0]  cdb_dest_q, cdb_dest_d;
  logic [31:0]       cdb_val_q, cdb_val_d;

  logic        is_load, is_store, flush, done, ld_push, st_push;
  logic        launch, take_fifo, push;
  logic [31:0] eff_addr, ext_val;
  ld_req_t     issue_req, next_req;

  function automatic logic [1:0] len_of(input logic [TYPE_W-1:0] t);
    case (t)
      T_LH, T_LHU: len_of = 2'd1;
      T_LW:        len_of = 2'd2;
      default:     len_of = 2'd0;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (au_inst_type_in)
      T_LB, T_LH, T_LW, T_LBU, T_LHU: is_load  = 1'b1;
      T_SB, T_SH, T_SW:               is_store = 1'b1;
      default: ;
    endcase
  end

  // Everything is qualified by rdy_in: a stalled cycle sees no issue, done or flush.
  assign eff_addr  = au_vj_in + au_A_in;
  assign flush     = rdy_in & rob_flush_in;
  assign done      = rdy_in & memctrl_done_in;
  assign ld_push   = rdy_in & au_en_in & ~rob_flush_in & is_load;
  assign st_push   = rdy_in & au_en_in & ~rob_flush_in & is_store;
  assign issue_req = '{dest: au_dest_in, typ: au_inst_type_in, addr: eff_addr};
  // With an empty FIFO the incoming load goes straight to memory.
  assign next_req  = (cnt_q != '0) ? fifo_q[head_q] : issue_req;

  lsu_ext #(
    .TYPE_W(TYPE_W), .T_LB(T_LB), .T_LH(T_LH), .T_LBU(T_LBU), .T_LHU(T_LHU)
  ) u_ext (
    .typ(cur_q.typ),
    .raw(memctrl_data_in),
    .val(ext_val)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    mem_en_d   = mem_en_q;
    rob_en_d   = 1'b0;
    rob_dest_d = rob_dest_q;
    rob_addr_d = rob_addr_q;
    cdb_en_d   = 1'b0;
    cdb_dest_d = cdb_dest_q;
    cdb_val_d  = cdb_val_q;
    launch     = 1'b0;
    if (rdy_in) begin
      if (st_push) begin
        rob_en_d   = 1'b1;
        rob_dest_d = au_dest_in;
        rob_addr_d = eff_addr;
      end
      case (state_q)
        S_IDLE: launch = ~flush & ((cnt_q != '0) | ld_push);
        S_REQ: begin
          if (flush) begin
            // the in-flight read must still complete; its data is dropped
            if (done) begin
              mem_en_d = 1'b0;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_DRAIN;
            end
          end else if (done) begin
            cdb_en_d   = 1'b1;
            cdb_dest_d = cur_q.dest;
            cdb_val_d  = ext_val;
            launch     = (cnt_q != '0) | ld_push;
            if (!launch) begin
              mem_en_d = 1'b0;
              state_d  = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (done) begin
            mem_en_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (launch) begin
        cur_d    = next_req;
        mem_en_d = 1'b1;
        state_d  = S_REQ;
      end
    end
  end

  always_comb begin
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    take_fifo = launch & (cnt_q != '0);
    // a push into a full FIFO is a protocol violation and is dropped
    push      = ld_push & ~(launch & (cnt_q == '0)) & (cnt_q != CNT_W'(DEPTH));
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        fifo_d[tail_q] = issue_req;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (take_fifo) head_d = head_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(take_fifo);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      mem_en_q   <= 1'b0;
      rob_en_q   <= 1'b0;
      rob_dest_q <= '0;
      rob_addr_q <= '0;
      cdb_en_q   <= 1'b0;
      cdb_dest_q <= '0;
      cdb_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      mem_en_q   <= mem_en_d;
      rob_en_q   <= rob_en_d;
      rob_dest_q <= rob_dest_d;
      rob_addr_q <= rob_addr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_dest_q <= cdb_dest_d;
      cdb_val_q  <= cdb_val_d;
    end
  end

  // One slot of slack covers upstream's registered issue decision.
  assign lbuffer_rdy_out = (state_q != S_DRAIN) &&
                           (((CNT_W+1)'(cnt_q) + (CNT_W+1)'(ld_push)) <= RDY_MAX);

  assign rob_addr_en_out       = rob_en_q;
  assign rob_addr_dest_out     = rob_dest_q;
  assign rob_addr_out          = rob_addr_q;
  assign memctrl_en_out        = mem_en_q;
  assign memctrl_addr_out      = cur_q.addr;
  assign memctrl_len_out       = len_of(cur_q.typ);
  assign cdb_lbuffer_en_out    = cdb_en_q;
  assign cdb_lbuffer_dest_out  = cdb_dest_q;
  assign cdb_lbuffer_value_out = cdb_val_q;
endmodule

// File: tb/tb_lsu_exec.sv
// Bench for lsu_exec: vector table, directed corner sequences, and a random
// run checked against a queue-based reference model.
module tb_lsu_exec;
  localparam int DEPTH = 4;
  localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5,
                         SB = 6'd6, SH = 6'd7, SW = 6'd8;

  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        au_en_in = 1'b0, rob_flush_in = 1'b0, memctrl_done_in = 1'b0;
  logic [31:0] au_A_in = '0, au_vj_in = '0, memctrl_data_in = '0;
  logic [3:0]  au_dest_in = '0;
  logic [5:0]  au_inst_type_in = '0;
  logic        lbuffer_rdy_out, rob_addr_en_out, memctrl_en_out, cdb_lbuffer_en_out;
  logic [3:0]  rob_addr_dest_out, cdb_lbuffer_dest_out;
  logic [31:0] rob_addr_out, memctrl_addr_out, cdb_lbuffer_value_out;
  logic [1:0]  memctrl_len_out;

  always #5 clk_in = ~clk_in;

  lsu_exec #(.DEPTH(DEPTH), .ROB_W(4), .TYPE_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .au_en_in(au_en_in),
    .au_A_in(au_A_in), .au_vj_in(au_vj_in), .au_dest_in(au_dest_in),
    .au_inst_type_in(au_inst_type_in), .lbuffer_rdy_out(lbuffer_rdy_out),
    .rob_flush_in(rob_flush_in), .rob_addr_en_out(rob_addr_en_out),
    .rob_addr_dest_out(rob_addr_dest_out), .rob_addr_out(rob_addr_out),
    .memctrl_en_out(memctrl_en_out), .memctrl_addr_out(memctrl_addr_out),
    .memctrl_len_out(memctrl_len_out), .memctrl_done_in(memctrl_done_in),
    .memctrl_data_in(memctrl_data_in), .cdb_lbuffer_en_out(cdb_lbuffer_en_out),
    .cdb_lbuffer_dest_out(cdb_lbuffer_dest_out),
    .cdb_lbuffer_value_out(cdb_lbuffer_value_out)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic idle_in();
    au_en_in = 0; rob_flush_in = 0; memctrl_done_in = 0;
  endtask

  task automatic issue(input logic [5:0] t, input logic [3:0] d, input logic [31:0] vj,
                       input logic [31:0] a);
    au_en_in = 1; au_inst_type_in = t; au_dest_in = d; au_vj_in = vj; au_A_in = a;
  endtask

  function automatic bit is_ld(input logic [5:0] t);
    return t == LB || t == LH || t == LW || t == LBU || t == LHU;
  endfunction

  function automatic logic [1:0] ref_len(input logic [5:0] t);
    if (t == LW) return 2'd2;
    if (t == LH || t == LHU) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [5:0] t, input logic [31:0] d);
    case (t)
      LB:      return d[7]  ? (d | 32'hFFFF_FF00) : (d & 32'h0000_00FF);
      LBU:     return d & 32'h0000_00FF;
      LH:      return d[15] ? (d | 32'hFFFF_0000) : (d & 32'h0000_FFFF);
      LHU:     return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  typedef struct {
    logic [5:0]  typ;
    logic [31:0] vj, a;
    logic [3:0]  dest;
    logic [31:0] data, exp_addr;
    logic [1:0]  exp_len;
    logic [31:0] exp_val;
  } vec_t;
  vec_t vt [10];

  typedef struct { logic [3:0] dest; logic [5:0] typ; logic [31:0] addr; } ld_t;
  ld_t         pend [$];
  ld_t         cur, nl;
  bit          busy, exp_rob, exp_cdb, up_rdy, r_push;
  int          lat, issued;
  logic [3:0]  exp_rob_dest, exp_cdb_dest;
  logic [31:0] exp_rob_addr, exp_cdb_val;
  logic [5:0]  tcodes [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    #1 rst_in = 0;
    #2;
    chk("rst_mem_en", memctrl_en_out, 0);
    chk("rst_rob_en", rob_addr_en_out, 0);
    chk("rst_cdb_en", cdb_lbuffer_en_out, 0);
    chk("rst_mem_addr", memctrl_addr_out, 0);
    chk("rst_lbuf_rdy", lbuffer_rdy_out, 1);
    #9 rst_in = 1;
    tick();

    vt[0] = '{SW,  32'h0000_1000, 32'hFFFF_FFFC, 4'd3,  32'h0,         32'h0000_0FFC, 2'd0, 32'h0};
    vt[1] = '{LB,  32'h0000_0020, 32'h0,         4'd1,  32'h80,        32'h0000_0020, 2'd0, 32'hFFFF_FF80};
    vt[2] = '{LBU, 32'h0000_0010, 32'h10,        4'd2,  32'h80,        32'h0000_0020, 2'd0, 32'h0000_0080};
    vt[3] = '{LH,  32'h0000_0100, 32'h2,         4'd5,  32'h8001,      32'h0000_0102, 2'd1, 32'hFFFF_8001};
    vt[4] = '{LHU, 32'h0000_0100, 32'hFFFF_FFFE, 4'd6,  32'h8001,      32'h0000_00FE, 2'd1, 32'h0000_8001};
    vt[5] = '{LW,  32'hFFFF_FFF0, 32'h14,        4'd7,  32'h1234_5678, 32'h0000_0004, 2'd2, 32'h1234_5678};
    vt[6] = '{SB,  32'h0000_0007, 32'h1,         4'd9,  32'h0,         32'h0000_0008, 2'd0, 32'h0};
    vt[7] = '{SH,  32'h8000_0000, 32'h8000_0000, 4'd15, 32'h0,         32'h0000_0000, 2'd0, 32'h0};
    vt[8] = '{LB,  32'h0000_0040, 32'h1,         4'd4,  32'h7F,        32'h0000_0041, 2'd0, 32'h0000_007F};
    vt[9] = '{LH,  32'h0000_0050, 32'h2,         4'd8,  32'h7FFF,      32'h0000_0052, 2'd1, 32'h0000_7FFF};

    for (int i = 0; i < 10; i++) begin
      idle_in();
      issue(vt[i].typ, vt[i].dest, vt[i].vj, vt[i].a);
      tick();
      au_en_in = 0;
      if (!is_ld(vt[i].typ)) begin
        chk("st_en", rob_addr_en_out, 1);
        chk("st_dest", rob_addr_dest_out, vt[i].dest);
        chk("st_addr", rob_addr_out, vt[i].exp_addr);
        chk("st_no_mem", memctrl_en_out, 0);
        tick();
        chk("st_one_cycle", rob_addr_en_out, 0);
      end else begin
        chk("ld_req", memctrl_en_out, 1);
        chk("ld_addr", memctrl_addr_out, vt[i].exp_addr);
        chk("ld_len", memctrl_len_out, vt[i].exp_len);
        chk("ld_no_rob", rob_addr_en_out, 0);
        tick();
        chk("ld_hold", memctrl_en_out, 1);
        chk("ld_no_cdb_early", cdb_lbuffer_en_out, 0);
        memctrl_done_in = 1; memctrl_data_in = vt[i].data;
        tick();
        memctrl_done_in = 0;
        chk("ld_cdb_en", cdb_lbuffer_en_out, 1);
        chk("ld_cdb_dest", cdb_lbuffer_dest_out, vt[i].dest);
        chk("ld_cdb_val", cdb_lbuffer_value_out, vt[i].exp_val);
        chk("ld_req_drop", memctrl_en_out, 0);
        tick();
        chk("ld_cdb_one_cycle", cdb_lbuffer_en_out, 0);
      end
    end

    // backpressure: memory stalled, upstream issues whenever ready was seen
    idle_in(); issued = 0; up_rdy = 1;
    for (int c = 0; c < 6; c++) begin
      au_en_in = 0;
      if (up_rdy) issue(LW, 4'(issued + 1), 32'(256 * (issued + 1)), 32'h0);
      #1;
      if (au_en_in) issued++;
      up_rdy = lbuffer_rdy_out;
      if (c == 2) chk("bp_rdy_cnt2", lbuffer_rdy_out, 1);
      if (c == 3) chk("bp_rdy_cnt3", lbuffer_rdy_out, 0);
      tick();
    end
    au_en_in = 0;
    chk("bp_issued", issued, 4);
    chk("bp_rdy_full", lbuffer_rdy_out, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("bp_req", memctrl_en_out, 1);
      chk("bp_addr", memctrl_addr_out, 32'(256 * k));
      memctrl_done_in = 1; memctrl_data_in = 32'hA000 + 32'(k);
      tick();
      memctrl_done_in = 0;
      chk("bp_cdb_en", cdb_lbuffer_en_out, 1);
      chk("bp_cdb_dest", cdb_lbuffer_dest_out, 32'(k));
      chk("bp_cdb_val", cdb_lbuffer_value_out, 32'hA000 + 32'(k));
    end
    chk("bp_idle", memctrl_en_out, 0);
    chk("bp_rdy_back", lbuffer_rdy_out, 1);

    // flush in REQ, done three cycles later
    issue(LW, 4'd2, 32'h40, 32'h0); tick();
    issue(LH, 4'd3, 32'h44, 32'h0); tick();
    issue(SW, 4'd5, 32'h48, 32'h0); rob_flush_in = 1; tick();
    idle_in();
    chk("fl_drain_req", memctrl_en_out, 1);
    chk("fl_drain_addr", memctrl_addr_out, 32'h40);
    chk("fl_store_dropped", rob_addr_en_out, 0);
    chk("fl_rdy_low", lbuffer_rdy_out, 0);
    tick();
    chk("fl_drain_hold", memctrl_en_out, 1);
    chk("fl_rdy_low2", lbuffer_rdy_out, 0);
    tick();
    memctrl_done_in = 1; memctrl_data_in = 32'hDEAD_BEEF;
    tick();
    memctrl_done_in = 0;
    chk("fl_no_cdb", cdb_lbuffer_en_out, 0);
    chk("fl_req_drop", memctrl_en_out, 0);
    chk("fl_rdy_back", lbuffer_rdy_out, 1);
    tick();
    chk("fl_fifo_empty", memctrl_en_out, 0);

    // flush coinciding with done
    issue(LW, 4'd6, 32'h60, 32'h0); tick();
    idle_in(); rob_flush_in = 1; memctrl_done_in = 1; memctrl_data_in = 32'h1;
    tick();
    idle_in();
    chk("fd_no_cdb", cdb_lbuffer_en_out, 0);
    chk("fd_idle", memctrl_en_out, 0);
    chk("fd_rdy", lbuffer_rdy_out, 1);
    issue(LBU, 4'd11, 32'h70, 32'h0); tick(); au_en_in = 0;
    chk("fd_next_req", memctrl_en_out, 1);
    chk("fd_next_addr", memctrl_addr_out, 32'h70);
    memctrl_done_in = 1; memctrl_data_in = 32'hF0; tick(); memctrl_done_in = 0;
    chk("fd_next_cdb", cdb_lbuffer_value_out, 32'hF0);

    // stall with done pulsing
    issue(LB, 4'd7, 32'h33, 32'h0); tick();
    for (int c = 0; c < 5; c++) begin
      rdy_in = 0; memctrl_done_in = 1; memctrl_data_in = 32'hFF;
      issue(SW, 4'd9, 32'h0, 32'h4);
      tick();
      chk("stl_req_hold", memctrl_en_out, 1);
      chk("stl_addr_hold", memctrl_addr_out, 32'h33);
      chk("stl_no_cdb", cdb_lbuffer_en_out, 0);
      chk("stl_no_rob", rob_addr_en_out, 0);
    end
    rdy_in = 1; idle_in(); tick();
    chk("stl_still_req", memctrl_en_out, 1);
    chk("stl_still_no_cdb", cdb_lbuffer_en_out, 0);
    memctrl_done_in = 1; memctrl_data_in = 32'h7F; tick(); memctrl_done_in = 0;
    chk("stl_cdb_en", cdb_lbuffer_en_out, 1);
    chk("stl_cdb_dest", cdb_lbuffer_dest_out, 7);
    chk("stl_cdb_val", cdb_lbuffer_value_out, 32'h7F);

    // asynchronous reset in the middle of a request
    issue(LW, 4'd5, 32'h500, 32'h0); tick(); au_en_in = 0;
    chk("ar_pre_req", memctrl_en_out, 1);
    #2 rst_in = 0;
    #1;
    chk("ar_mem_en", memctrl_en_out, 0);
    chk("ar_mem_addr", memctrl_addr_out, 0);
    chk("ar_mem_len", memctrl_len_out, 0);
    chk("ar_cdb", cdb_lbuffer_en_out, 0);
    #3 rst_in = 1;
    tick();
    chk("ar_rdy_after", lbuffer_rdy_out, 1);
    chk("ar_idle_after", memctrl_en_out, 0);

    // random traffic against the reference model
    pend.delete(); busy = 0; exp_rob = 0; exp_cdb = 0; up_rdy = 1; lat = 0;
    for (int c = 0; c < 1600; c++) begin
      chk("rnd_rob_en", rob_addr_en_out, exp_rob);
      if (exp_rob) begin
        chk("rnd_rob_dest", rob_addr_dest_out, exp_rob_dest);
        chk("rnd_rob_addr", rob_addr_out, exp_rob_addr);
      end
      chk("rnd_cdb_en", cdb_lbuffer_en_out, exp_cdb);
      if (exp_cdb) begin
        chk("rnd_cdb_dest", cdb_lbuffer_dest_out, exp_cdb_dest);
        chk("rnd_cdb_val", cdb_lbuffer_value_out, exp_cdb_val);
      end
      if (busy) begin
        chk("rnd_req_hold", memctrl_en_out, 1);
        chk("rnd_req_addr_hold", memctrl_addr_out, cur.addr);
      end else begin
        chk("rnd_req_vs_model", memctrl_en_out, pend.size() != 0);
        if (memctrl_en_out && pend.size() != 0) begin
          cur = pend.pop_front(); busy = 1; lat = $urandom_range(3, 0);
          chk("rnd_req_addr", memctrl_addr_out, cur.addr);
          chk("rnd_req_len", memctrl_len_out, ref_len(cur.typ));
        end
      end
      rdy_in = ($urandom_range(7, 0) != 0);
      memctrl_done_in = 0;
      memctrl_data_in = $urandom;
      if (busy) begin
        if (lat == 0) begin
          memctrl_done_in = 1;
          memctrl_data_in = memctrl_data_in &
            ((ref_len(cur.typ) == 2'd0) ? 32'hFF : (ref_len(cur.typ) == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF);
        end else lat--;
      end
      au_en_in = 0;
      if (c < 1500 && up_rdy && $urandom_range(2, 0) != 0)
        issue(tcodes[$urandom_range(7, 0)], 4'($urandom_range(15, 1)), $urandom,
              ($urandom_range(1, 0) != 0) ? 32'($urandom_range(64, 0)) : $urandom);
      #1;
      r_push = rdy_in && au_en_in && is_ld(au_inst_type_in);
      chk("rnd_lbuf_rdy", lbuffer_rdy_out, (pend.size() + int'(r_push)) <= DEPTH - 2);
      up_rdy = lbuffer_rdy_out;
      exp_rob = rdy_in && au_en_in && !is_ld(au_inst_type_in);
      if (exp_rob) begin
        exp_rob_dest = au_dest_in;
        exp_rob_addr = au_vj_in + au_A_in;
      end
      exp_cdb = rdy_in && memctrl_done_in && busy;
      if (exp_cdb) begin
        exp_cdb_dest = cur.dest;
        exp_cdb_val  = ref_ext(cur.typ, memctrl_data_in);
        busy = 0;
      end
      if (r_push) begin
        nl.dest = au_dest_in; nl.typ = au_inst_type_in; nl.addr = au_vj_in + au_A_in;
        pend.push_back(nl);
      end
      tick();
    end
    chk("rnd_drained", pend.size() + int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
